if_id_reg: RTL and testbench
============================

Name: if_id_reg

Overview:
- IF/ID pipeline register of the 5-stage RV32I core; sits directly downstream of the fetch stage and feeds decode.
- Captures instruction word, PC and PC+4 from fetch.
- Inserts NOP bubbles on branch flush, instruction-memory not-ready and post-reset warm-up; holds on hazard stall.
- Pre-extracts rs1/rs2/rd for the hazard unit and keeps a bubble performance counter.

Parameters:
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0).
- RESET_PC, 32'h0001_0000, PC value presented while in reset.
- FLUSH_BUBBLES, 1, total bubble cycles per flush (range 1..7).
- CNT_W, 16, width of bubble counter.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- keep  in  1  hazard stall; hold all outputs.
- flush  in  1  branch taken (early or late); discard captured instruction.
- iready_n  in  1  instruction memory not ready (1 = instr_in invalid).
- instr_in  in  32  instruction word from fetch.
- pc_in  in  32  PC of instr_in.
- pcp4_in  in  32  PC+4 of instr_in.
- valid_out  out  1  1 = instr_out is a real instruction.
- instr_out  out  32  instruction to decode.
- pc_out  out  32  registered PC.
- pcp4_out  out  32  registered PC+4.
- rs1_out  out  5  instr_out[19:15], 0 on bubble.
- rs2_out  out  5  instr_out[24:20], 0 on bubble.
- rd_out  out  5  instr_out[11:7], 0 on bubble.
- bubble_cnt  out  CNT_W  count of bubbles loaded.

Behaviour:
- Reset (rst=1 at edge): valid_out=0, instr_out=NOP_INSTR, pc_out=RESET_PC, pcp4_out=RESET_PC+4, rs1/rs2/rd=0, bubble_cnt=0, state=WARMUP, flush counter=0. Reset overrides all other inputs, including mid-flush or mid-stall.
- All outputs are registered. Latency is 1 cycle from input to output.
- State WARMUP: first edge after rst deasserts loads a bubble and moves to RUN. flush and keep are ignored in this state.
- State RUN: per edge, priority is flush > keep > iready_n > capture.
  - flush=1: load bubble. If FLUSH_BUBBLES>1, go to FLUSH with counter=FLUSH_BUBBLES-1; otherwise stay in RUN.
  - keep=1: hold all outputs and bubble_cnt unchanged.
  - iready_n=1: load bubble; pc_out/pcp4_out hold.
  - Otherwise (capture): instr_out=instr_in, pc_out=pc_in, pcp4_out=pcp4_in, valid_out=1, rs1/rs2/rd from instr_in fields.
- State FLUSH: each edge loads a bubble.
  - keep=1: counter does not decrement.
  - flush=1: counter reloads to FLUSH_BUBBLES-1.
  - Otherwise the counter decrements; when it reaches 0, go to RUN.
- Loading a bubble means: valid_out=0, instr_out=NOP_INSTR, rs1/rs2/rd=0, and pc_out/pcp4_out are held. Every bubble load increments bubble_cnt. A held bubble during keep does not increment it. bubble_cnt wraps modulo 2^CNT_W.
- Simultaneous flush+keep in RUN: flush wins, bubble loaded.
- Simultaneous flush+iready_n: single bubble, counted once.
- Outputs are never X after the first reset edge. Unused instruction bits are passed through unmodified.

Test Plan:
- Reset, then deassert; present instr_in=32'h00500093 (addi x1,x0,5), pc_in=32'h0001_0000 on cycle 2 → cycle 1 output is a bubble (bubble_cnt=1); cycle 2 gives valid_out=1, rd_out=1, rs1_out=0, pc_out=32'h0001_0000, pcp4_out=32'h0001_0004.
- Stream of 4 sequential instructions at PCs 0x10000..0x1000C → valid_out=1 each cycle, outputs track inputs with 1-cycle latency, bubble_cnt stays constant.
- keep=1 for 3 cycles while instr_in changes → outputs frozen at the prior values, bubble_cnt unchanged; the capture after release matches the instr_in value on that edge.
- FLUSH_BUBBLES=2, flush pulse in RUN → exactly 2 consecutive NOP_INSTR outputs with valid_out=0, bubble_cnt+=2, then capture resumes. Repeat with keep=1 during the second bubble → bubble extends until keep drops.
- iready_n=1 for 2 cycles → 2 bubbles, pc_out held, bubble_cnt+=2. Repeat with flush and keep high together → bubble loaded, single increment.
- Assert rst while in FLUSH with keep=1 → all outputs return to reset values next edge and state is WARMUP.

Source files
------------

// File: rtl/if_id_reg_if.sv
// rtl/if_id_reg_if.sv - fetch/decode bundle for the IF/ID pipeline register
//
// Purpose: groups the fetch-side inputs and decode-side outputs of the IF/ID
// register so fetch, decode and the hazard unit connect through one port.
//
// Signals (direction as seen by the register, i.e. the slave modport):
//   keep        in   hazard stall, hold all outputs
//   flush       in   branch taken, discard captured instruction
//   iready_n    in   instruction memory not ready (instr_in invalid)
//   instr_in    in   instruction word from fetch
//   pc_in       in   PC of instr_in
//   pcp4_in     in   PC+4 of instr_in
//   valid_out   out  instr_out is a real instruction
//   instr_out   out  instruction to decode
//   pc_out      out  registered PC
//   pcp4_out    out  registered PC+4
//   rs1_out     out  instr_out[19:15], 0 on bubble
//   rs2_out     out  instr_out[24:20], 0 on bubble
//   rd_out      out  instr_out[11:7], 0 on bubble
//   bubble_cnt  out  number of bubbles loaded (wraps)

interface if_id_reg_if #(
    parameter int CNT_W = 16
);
    logic             keep;
    logic             flush;
    logic             iready_n;
    logic [31:0]      instr_in;
    logic [31:0]      pc_in;
    logic [31:0]      pcp4_in;
    logic             valid_out;
    logic [31:0]      instr_out;
    logic [31:0]      pc_out;
    logic [31:0]      pcp4_out;
    logic [4:0]       rs1_out;
    logic [4:0]       rs2_out;
    logic [4:0]       rd_out;
    logic [CNT_W-1:0] bubble_cnt;

    // Fetch / hazard side: drives the stage inputs, observes the outputs.
    modport master (
        output keep,
        output flush,
        output iready_n,
        output instr_in,
        output pc_in,
        output pcp4_in,
        input  valid_out,
        input  instr_out,
        input  pc_out,
        input  pcp4_out,
        input  rs1_out,
        input  rs2_out,
        input  rd_out,
        input  bubble_cnt
    );

    // The pipeline register itself.
    modport slave (
        input  keep,
        input  flush,
        input  iready_n,
        input  instr_in,
        input  pc_in,
        input  pcp4_in,
        output valid_out,
        output instr_out,
        output pc_out,
        output pcp4_out,
        output rs1_out,
        output rs2_out,
        output rd_out,
        output bubble_cnt
    );
endinterface

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with bubble insertion and counter
//
// Purpose: registers instruction, PC and PC+4 from fetch for the decode stage.
// Inserts NOP bubbles after reset (one warm-up cycle), on a taken branch
// (FLUSH_BUBBLES cycles) and while instruction memory is not ready; holds
// everything while the hazard unit asserts keep. Register-source/destination
// fields are pre-extracted for the hazard unit and forced to 0 on bubbles.
//
// Ports:
//   clk   in   clock, all state updates on the rising edge
//   rst   in   synchronous active-high reset
//   bus   slave modport of if_id_reg_if (see that file for signal list)
//
// Parameters:
//   NOP_INSTR      bubble encoding (addi x0,x0,0)
//   RESET_PC       PC presented while in reset
//   FLUSH_BUBBLES  total bubble cycles per flush, 1..7
//   CNT_W          bubble counter width, must match the interface

module if_id_reg #(
    parameter logic [31:0] NOP_INSTR     = 32'h0000_0013,
    parameter logic [31:0] RESET_PC      = 32'h0001_0000,
    parameter int          FLUSH_BUBBLES = 1,
    parameter int          CNT_W         = 16
) (
    input  logic         clk,
    input  logic         rst,
    if_id_reg_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_WARMUP = 2'd0,
        ST_RUN    = 2'd1,
        ST_FLUSH  = 2'd2
    } state_t;

    // The first flush bubble is loaded on the edge that sees flush, so the
    // FLUSH state only has to produce the remaining FLUSH_BUBBLES-1.
    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_BUBBLES - 1);

    state_t           state_q, state_d;
    logic [2:0]       fcnt_q, fcnt_d;
    logic             valid_q, valid_d;
    logic [31:0]      instr_q, instr_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      pcp4_q, pcp4_d;
    logic [4:0]       rs1_q, rs1_d;
    logic [4:0]       rs2_q, rs2_d;
    logic [4:0]       rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             load_bubble;
    logic             capture;

    // Next-state and datapath select. Defaults hold every register, which
    // is exactly the keep behaviour.
    always_comb begin
        state_d     = state_q;
        fcnt_d      = fcnt_q;
        load_bubble = 1'b0;
        capture     = 1'b0;

        case (state_q)
            ST_WARMUP: begin
                // flush/keep/iready_n are ignored until the pipe is primed.
                load_bubble = 1'b1;
                state_d     = ST_RUN;
            end

            ST_RUN: begin
                if (bus.flush) begin
                    load_bubble = 1'b1;
                    if (FLUSH_BUBBLES > 1) begin
                        state_d = ST_FLUSH;
                        fcnt_d  = FLUSH_RELOAD;
                    end
                end else if (bus.keep) begin
                    load_bubble = 1'b0;
                end else if (bus.iready_n) begin
                    load_bubble = 1'b1;
                end else begin
                    capture = 1'b1;
                end
            end

            ST_FLUSH: begin
                if (bus.flush) begin
                    // A second branch during the shadow restarts the window.
                    load_bubble = 1'b1;
                    fcnt_d      = FLUSH_RELOAD;
                end else if (bus.keep) begin
                    // Bubble already showing; hold it without counting.
                    load_bubble = 1'b0;
                end else begin
                    load_bubble = 1'b1;
                    fcnt_d      = fcnt_q - 3'd1;
                    if (fcnt_q == 3'd1) begin
                        state_d = ST_RUN;
                    end
                end
            end

            default: begin
                load_bubble = 1'b1;
                state_d     = ST_WARMUP;
                fcnt_d      = 3'd0;
            end
        endcase
    end

    // Output register next values. PC/PC+4 are only ever updated on capture,
    // so bubbles keep the last real PC visible for exception/debug use.
    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        pcp4_d  = pcp4_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;

        if (load_bubble) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
            rs1_d   = 5'd0;
            rs2_d   = 5'd0;
            rd_d    = 5'd0;
            cnt_d   = cnt_q + CNT_W'(1);
        end else if (capture) begin
            valid_d = 1'b1;
            instr_d = bus.instr_in;
            pc_d    = bus.pc_in;
            pcp4_d  = bus.pcp4_in;
            rs1_d   = bus.instr_in[19:15];
            rs2_d   = bus.instr_in[24:20];
            rd_d    = bus.instr_in[11:7];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_WARMUP;
            fcnt_q  <= 3'd0;
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            pc_q    <= RESET_PC;
            pcp4_q  <= RESET_PC + 32'd4;
            rs1_q   <= 5'd0;
            rs2_q   <= 5'd0;
            rd_q    <= 5'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
            pcp4_q  <= pcp4_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.valid_out  = valid_q;
    assign bus.instr_out  = instr_q;
    assign bus.pc_out     = pc_q;
    assign bus.pcp4_out   = pcp4_q;
    assign bus.rs1_out    = rs1_q;
    assign bus.rs2_out    = rs2_q;
    assign bus.rd_out     = rd_q;
    assign bus.bubble_cnt = cnt_q;

endmodule

// File: tb/tb_if_id_reg.sv
// tb/tb_if_id_reg.sv - self-checking bench for if_id_reg

module tb_if_id_reg;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] RPC  = 32'h0001_0000;
    localparam int          FB   = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    if_id_reg_if #(.CNT_W(16)) bus ();

    if_id_reg #(
        .NOP_INSTR    (NOP),
        .RESET_PC     (RPC),
        .FLUSH_BUBBLES(FB),
        .CNT_W        (16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a pending warm-up flag plus the number of flush
    // bubbles still owed; everything else follows the stage rules directly.
    bit          m_live = 1'b0;
    bit          m_warm;
    int          m_rem;
    bit          m_valid;
    logic [31:0] m_instr, m_pc, m_pcp4;
    int          m_rs1, m_rs2, m_rd;
    int          m_cnt;

    always @(posedge clk) begin
        if (rst) begin
            m_live  <= 1'b1;
            m_warm  <= 1'b1;
            m_rem   <= 0;
            m_valid <= 1'b0;
            m_instr <= NOP;
            m_pc    <= RPC;
            m_pcp4  <= RPC + 32'd4;
            m_rs1   <= 0;
            m_rs2   <= 0;
            m_rd    <= 0;
            m_cnt   <= 0;
        end else if (m_live) begin
            if (m_warm || bus.flush || (!bus.keep && (m_rem > 0 || bus.iready_n))) begin
                m_valid <= 1'b0;
                m_instr <= NOP;
                m_rs1   <= 0;
                m_rs2   <= 0;
                m_rd    <= 0;
                m_cnt   <= (m_cnt + 1) % 65536;
                if (m_warm)
                    m_warm <= 1'b0;
                else if (bus.flush)
                    m_rem <= FB - 1;
                else if (m_rem > 0)
                    m_rem <= m_rem - 1;
            end else if (!bus.keep) begin
                m_valid <= 1'b1;
                m_instr <= bus.instr_in;
                m_pc    <= bus.pc_in;
                m_pcp4  <= bus.pcp4_in;
                m_rs1   <= int'((bus.instr_in >> 15) % 32);
                m_rs2   <= int'((bus.instr_in >> 20) % 32);
                m_rd    <= int'((bus.instr_in >> 7) % 32);
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("valid_out",  32'(bus.valid_out),  32'(m_valid));
            chk("instr_out",  bus.instr_out,       m_instr);
            chk("pc_out",     bus.pc_out,          m_pc);
            chk("pcp4_out",   bus.pcp4_out,        m_pcp4);
            chk("rs1_out",    32'(bus.rs1_out),    32'(m_rs1));
            chk("rs2_out",    32'(bus.rs2_out),    32'(m_rs2));
            chk("rd_out",     32'(bus.rd_out),     32'(m_rd));
            chk("bubble_cnt", 32'(bus.bubble_cnt), 32'(m_cnt));
        end
    end

    task automatic drive(input logic r, input logic f, input logic k, input logic ir,
                         input logic [31:0] ins, input logic [31:0] pc);
        rst          = r;
        bus.flush    = f;
        bus.keep     = k;
        bus.iready_n = ir;
        bus.instr_in = ins;
        bus.pc_in    = pc;
        bus.pcp4_in  = pc + 32'd4;
        @(negedge clk);
    endtask

    logic [31:0] prog [4];

    initial begin
        prog[0] = 32'h0010_8113;
        prog[1] = 32'h0020_81b3;
        prog[2] = 32'h4021_8233;
        prog[3] = 32'h0041_a2a3;

        rst          = 1'b1;
        bus.flush    = 1'b0;
        bus.keep     = 1'b0;
        bus.iready_n = 1'b0;
        bus.instr_in = 32'h0;
        bus.pc_in    = 32'h0;
        bus.pcp4_in  = 32'h4;
        @(negedge clk);
        @(negedge clk);

        chk("rst_valid", 32'(bus.valid_out), 32'd0);
        chk("rst_instr", bus.instr_out, 32'h0000_0013);
        chk("rst_pc",    bus.pc_out,    32'h0001_0000);
        chk("rst_pcp4",  bus.pcp4_out,  32'h0001_0004);
        chk("rst_cnt",   32'(bus.bubble_cnt), 32'd0);

        // warm-up bubble, then first capture
        drive(0, 0, 0, 0, 32'h0050_0093, 32'h0001_0000);
        chk("warm_valid", 32'(bus.valid_out), 32'd0);
        chk("warm_cnt",   32'(bus.bubble_cnt), 32'd1);
        drive(0, 0, 0, 0, 32'h0050_0093, 32'h0001_0000);
        chk("cap_valid", 32'(bus.valid_out), 32'd1);
        chk("cap_rd",    32'(bus.rd_out),    32'd1);
        chk("cap_rs1",   32'(bus.rs1_out),   32'd0);
        chk("cap_pc",    bus.pc_out,         32'h0001_0000);
        chk("cap_pcp4",  bus.pcp4_out,       32'h0001_0004);

        // sequential stream
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, prog[i], 32'h0001_0000 + 32'(4 * i));
            chk("stream_instr", bus.instr_out, prog[i]);
            chk("stream_pc",    bus.pc_out,    32'h0001_0000 + 32'(4 * i));
            chk("stream_cnt",   32'(bus.bubble_cnt), 32'd1);
        end

        // stall while input changes
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 0, 32'hdead_beef ^ 32'(i), 32'h0002_0000);
            chk("keep_instr", bus.instr_out, 32'h0041_a2a3);
            chk("keep_pc",    bus.pc_out,    32'h0001_000c);
            chk("keep_cnt",   32'(bus.bubble_cnt), 32'd1);
        end
        drive(0, 0, 0, 0, 32'h00c5_8533, 32'h0001_0010);
        chk("rel_instr", bus.instr_out, 32'h00c5_8533);
        chk("rel_rd",    32'(bus.rd_out),  32'd10);
        chk("rel_rs1",   32'(bus.rs1_out), 32'd11);
        chk("rel_rs2",   32'(bus.rs2_out), 32'd12);

        // flush: two bubbles then capture
        drive(0, 1, 0, 0, 32'h0000_0ff3, 32'h0001_0014);
        chk("fl1_instr", bus.instr_out, 32'h0000_0013);
        chk("fl1_pc",    bus.pc_out,    32'h0001_0010);
        chk("fl1_cnt",   32'(bus.bubble_cnt), 32'd2);
        drive(0, 0, 0, 0, 32'h0000_0ff3, 32'h0001_0100);
        chk("fl2_valid", 32'(bus.valid_out), 32'd0);
        chk("fl2_cnt",   32'(bus.bubble_cnt), 32'd3);
        drive(0, 0, 0, 0, 32'h0010_0113, 32'h0001_0100);
        chk("fl3_valid", 32'(bus.valid_out), 32'd1);

        // flush with keep during the second bubble
        drive(0, 1, 0, 0, 32'h0, 32'h0001_0104);
        chk("fk1_cnt", 32'(bus.bubble_cnt), 32'd4);
        drive(0, 0, 1, 0, 32'h0, 32'h0001_0200);
        drive(0, 0, 1, 0, 32'h0, 32'h0001_0200);
        chk("fk_hold_valid", 32'(bus.valid_out), 32'd0);
        chk("fk_hold_cnt",   32'(bus.bubble_cnt), 32'd4);
        drive(0, 0, 0, 0, 32'h0, 32'h0001_0200);
        chk("fk2_cnt",   32'(bus.bubble_cnt), 32'd5);
        chk("fk2_valid", 32'(bus.valid_out), 32'd0);
        drive(0, 0, 0, 0, 32'h0020_0193, 32'h0001_0200);
        chk("fk3_valid", 32'(bus.valid_out), 32'd1);

        // instruction memory not ready
        drive(0, 0, 0, 1, 32'h1234_5678, 32'h0001_0300);
        drive(0, 0, 0, 1, 32'h1234_5678, 32'h0001_0300);
        chk("ir_cnt",   32'(bus.bubble_cnt), 32'd7);
        chk("ir_pc",    bus.pc_out,    32'h0001_0200);
        chk("ir_instr", bus.instr_out, 32'h0000_0013);
        drive(0, 1, 1, 1, 32'h1234_5678, 32'h0001_0300);
        chk("fki_cnt", 32'(bus.bubble_cnt), 32'd8);
        drive(0, 0, 0, 0, 32'h0030_0213, 32'h0001_0400);
        chk("fki2_cnt", 32'(bus.bubble_cnt), 32'd9);
        drive(0, 0, 0, 0, 32'h0030_0213, 32'h0001_0400);
        chk("fki3_valid", 32'(bus.valid_out), 32'd1);

        // reset while in FLUSH with keep
        drive(0, 1, 0, 0, 32'h0, 32'h0001_0500);
        drive(1, 0, 1, 0, 32'h0, 32'h0001_0500);
        chk("rf_cnt",   32'(bus.bubble_cnt), 32'd0);
        chk("rf_pc",    bus.pc_out,    32'h0001_0000);
        chk("rf_instr", bus.instr_out, 32'h0000_0013);
        drive(0, 1, 1, 0, 32'h0040_0293, 32'h0001_0600);
        chk("rw_valid", 32'(bus.valid_out), 32'd0);
        chk("rw_cnt",   32'(bus.bubble_cnt), 32'd1);
        drive(0, 0, 0, 0, 32'h0040_0293, 32'h0001_0600);
        chk("rw2_valid", 32'(bus.valid_out), 32'd1);
        chk("rw2_rd",    32'(bus.rd_out),    32'd5);

        // randomized traffic, model compares every cycle
        for (int i = 0; i < 2000; i++) begin
            drive(($urandom_range(0, 199) == 0),
                  ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 5) == 0),
                  $urandom, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
